// File: rtl/memresp.sv
// Memory responder: one single-ported word array shared by an instruction read port and a
// data read/write port, with per-cycle arbitration and fixed-latency tagged read responses.
// Optional bounds checking is enabled by defining MEMRESP_BOUNDS_EN.
module memresp #(
   parameter int ADDR_W     = 24,
   parameter int DATA_W     = 24,
   parameter int DEPTH_LOG2 = 12,
   parameter int LAT        = 2,
   parameter int STARVE_MAX = 3,
   parameter int TAG_W      = 4
) (
   input  logic              iw_clk,
   input  logic              iw_rst,
   input  logic              iw_i_valid,
   input  logic [ADDR_W-1:0] iw_i_addr,
   output logic              ow_i_ready,
   output logic              ow_i_rvalid,
   output logic [DATA_W-1:0] ow_i_rdata,
   output logic [ADDR_W-1:0] ow_i_raddr,
   input  logic              iw_d_valid,
   input  logic              iw_d_we,
   input  logic [ADDR_W-1:0] iw_d_addr,
   input  logic [DATA_W-1:0] iw_d_wdata,
   input  logic [TAG_W-1:0]  iw_d_tag,
   output logic              ow_d_ready,
   output logic              ow_d_rvalid,
   output logic [DATA_W-1:0] ow_d_rdata,
   output logic [TAG_W-1:0]  ow_d_rtag,
   output logic              ow_fault
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   // Handshake: a request transfers on a cycle where valid and ready are both high; ready is
   // combinational from valid and the starvation counter, and requestors hold valid/payload until ready.

   typedef struct packed {
      logic              v;
      logic              is_d;
      logic [ADDR_W-1:0] id;    // I: full request address, D: zero-extended tag
      logic [DATA_W-1:0] data;
   } pipe_t;

   logic [DATA_W-1:0]     mem [DEPTH];
   pipe_t                 pipe [LAT];
   pipe_t                 stage_in;
   pipe_t                 last;
   logic [CNT_W-1:0]      starve_cnt;
   logic                  force_i, grant_d, grant_i;
   logic [DEPTH_LOG2-1:0] d_idx, i_idx, rd_idx;
   logic                  d_oob, i_oob, rd_oob;

   assign d_idx = iw_d_addr[DEPTH_LOG2-1:0];
   assign i_idx = iw_i_addr[DEPTH_LOG2-1:0];

`ifdef MEMRESP_BOUNDS_EN
   assign d_oob = |iw_d_addr[ADDR_W-1:DEPTH_LOG2];
   assign i_oob = |iw_i_addr[ADDR_W-1:DEPTH_LOG2];
`else
   logic unused_d_hi;
   assign unused_d_hi = ^iw_d_addr[ADDR_W-1:DEPTH_LOG2];
   assign d_oob = 1'b0;
   assign i_oob = 1'b0;
`endif

   always_comb begin
      force_i = iw_i_valid & iw_d_valid & (starve_cnt == CNT_W'(STARVE_MAX));
      grant_d = ~iw_rst & iw_d_valid & ~force_i;
      grant_i = ~iw_rst & iw_i_valid & ~grant_d;
   end

   assign ow_d_ready = grant_d;
   assign ow_i_ready = grant_i;

   always_ff @(posedge iw_clk) begin
      if (iw_rst)
         starve_cnt <= '0;
      else if (grant_i || !iw_i_valid)
         starve_cnt <= '0;
      else if (grant_d && starve_cnt != CNT_W'(STARVE_MAX))
         starve_cnt <= starve_cnt + 1'b1;
   end

   always_ff @(posedge iw_clk) begin
      if (grant_d && iw_d_we && !d_oob)
         mem[d_idx] <= iw_d_wdata;
   end

   // Only one port is granted per cycle, so the single array read serves whichever won.
   always_comb begin
      rd_idx        = grant_d ? d_idx : i_idx;
      rd_oob        = grant_d ? d_oob : i_oob;
      stage_in      = '0;
      stage_in.v    = (grant_d & ~iw_d_we) | grant_i;
      stage_in.is_d = grant_d;
      stage_in.id   = grant_d ? ADDR_W'(iw_d_tag) : iw_i_addr;
      stage_in.data = rd_oob ? '0 : mem[rd_idx];
   end

   always_ff @(posedge iw_clk) begin
      if (iw_rst) begin
         for (int i = 0; i < LAT; i++)
            pipe[i] <= '0;
      end else begin
         pipe[0] <= stage_in;
         for (int i = 1; i < LAT; i++)
            pipe[i] <= pipe[i-1];
      end
   end

   assign last        = pipe[LAT-1];
   assign ow_i_rvalid = last.v & ~last.is_d;
   assign ow_d_rvalid = last.v & last.is_d;
   assign ow_i_rdata  = ow_i_rvalid ? last.data : '0;
   assign ow_i_raddr  = ow_i_rvalid ? last.id : '0;
   assign ow_d_rdata  = ow_d_rvalid ? last.data : '0;
   assign ow_d_rtag   = ow_d_rvalid ? last.id[TAG_W-1:0] : '0;

`ifdef MEMRESP_BOUNDS_EN
   always_ff @(posedge iw_clk) begin
      if (iw_rst)
         ow_fault <= 1'b0;
      else if ((grant_d && d_oob) || (grant_i && i_oob))
         ow_fault <= 1'b1;
   end
`else
   assign ow_fault = 1'b0;
`endif

endmodule

// File: tb/tb_memresp.sv
// Bench for memresp: directed scenarios then randomized traffic, checked against a
// cycle-indexed reference model (word map plus a queue of due responses).
module tb_memresp;

   localparam int ADDR_W     = 24;
   localparam int DATA_W     = 24;
   localparam int DEPTH      = 4096;
   localparam int LAT        = 2;
   localparam int STARVE_MAX = 3;
   localparam int TAG_W      = 4;
   localparam int EW         = 32 + 1 + ADDR_W + DATA_W;
`ifdef MEMRESP_BOUNDS_EN
   localparam bit BOUNDS = 1'b1;
`else
   localparam bit BOUNDS = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              i_valid, i_ready, i_rvalid;
   logic [ADDR_W-1:0] i_addr, i_raddr;
   logic [DATA_W-1:0] i_rdata;
   logic              d_valid, d_we, d_ready, d_rvalid;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata, d_rdata;
   logic [TAG_W-1:0]  d_tag, d_rtag;
   logic              fault;

   // clock / reset block
   always #5 clk = ~clk;

   memresp dut (
      .iw_clk(clk), .iw_rst(rst),
      .iw_i_valid(i_valid), .iw_i_addr(i_addr), .ow_i_ready(i_ready),
      .ow_i_rvalid(i_rvalid), .ow_i_rdata(i_rdata), .ow_i_raddr(i_raddr),
      .iw_d_valid(d_valid), .iw_d_we(d_we), .iw_d_addr(d_addr), .iw_d_wdata(d_wdata),
      .iw_d_tag(d_tag), .ow_d_ready(d_ready), .ow_d_rvalid(d_rvalid),
      .ow_d_rdata(d_rdata), .ow_d_rtag(d_rtag), .ow_fault(fault)
   );

   // scoreboard: expected responses {due_cycle, is_d, addr_or_tag, data}
   logic [EW-1:0]     exp_q[$];
   logic [DATA_W-1:0] mdl_mem [int];
   int                cyc = 0;
   int                streak = 0;
   bit                m_fault = 1'b0;
   bit                primed = 1'b0;
   bit                m_gi, m_gd;
   int                n_checks = 0;
   int                n_fail = 0;
   logic [7:0]        g_pat;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] mdl_read(input logic [ADDR_W-1:0] a);
      int k;
      k = int'(a) % DEPTH;
      if (BOUNDS && int'(a) >= DEPTH) return '0;
      return mdl_mem.exists(k) ? mdl_mem[k] : 'x;
   endfunction

   // driver: one full clock cycle with the given inputs, checked and then modelled
   task automatic step(input logic r, input logic iv, input logic [ADDR_W-1:0] ia,
                       input logic dv, input logic dwe, input logic [ADDR_W-1:0] da,
                       input logic [DATA_W-1:0] dwd, input logic [TAG_W-1:0] dt);
      logic [EW-1:0]     e;
      logic [DATA_W-1:0] rd;
      @(negedge clk);
      rst = r; i_valid = iv; i_addr = ia;
      d_valid = dv; d_we = dwe; d_addr = da; d_wdata = dwd; d_tag = dt;
      #1;
      m_gd = !r && dv && !(iv && streak == STARVE_MAX);
      m_gi = !r && iv && !m_gd;
      chk("i_ready", 64'(i_ready), 64'(m_gi));
      chk("d_ready", 64'(d_ready), 64'(m_gd));
      if (primed) begin
         if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) == cyc) begin
            e = exp_q.pop_front();
            if (e[DATA_W+ADDR_W]) begin
               chk("d_rvalid", 64'(d_rvalid), 64'd1);
               chk("i_rvalid_quiet", 64'(i_rvalid), 64'd0);
               chk("d_rdata", 64'(d_rdata), 64'(e[DATA_W-1:0]));
               chk("d_rtag", 64'(d_rtag), 64'(e[DATA_W +: TAG_W]));
            end else begin
               chk("i_rvalid", 64'(i_rvalid), 64'd1);
               chk("d_rvalid_quiet", 64'(d_rvalid), 64'd0);
               chk("i_rdata", 64'(i_rdata), 64'(e[DATA_W-1:0]));
               chk("i_raddr", 64'(i_raddr), 64'(e[DATA_W +: ADDR_W]));
            end
         end else begin
            chk("i_rvalid_idle", 64'(i_rvalid), 64'd0);
            chk("d_rvalid_idle", 64'(d_rvalid), 64'd0);
         end
         chk("fault", 64'(fault), 64'(m_fault));
      end
      g_pat = {g_pat[6:0], i_ready};
      if (r) begin
         exp_q.delete();
         m_fault = 1'b0;
         streak  = 0;
         primed  = 1'b1;
      end else begin
         if (m_gd) begin
            if (BOUNDS && int'(da) >= DEPTH) m_fault = 1'b1;
            if (dwe) begin
               if (!(BOUNDS && int'(da) >= DEPTH)) mdl_mem[int'(da) % DEPTH] = dwd;
            end else begin
               rd = mdl_read(da);
               exp_q.push_back({32'(cyc + LAT), 1'b1, ADDR_W'(dt), rd});
            end
         end
         if (m_gi) begin
            if (BOUNDS && int'(ia) >= DEPTH) m_fault = 1'b1;
            rd = mdl_read(ia);
            exp_q.push_back({32'(cyc + LAT), 1'b0, ia, rd});
         end
         streak = (m_gd && iv) ? ((streak < STARVE_MAX) ? streak + 1 : STARVE_MAX) : 0;
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   logic              ri_pend, rd_pend, rd_we;
   logic [ADDR_W-1:0] ri_a, rd_a;
   logic [DATA_W-1:0] rd_wd;
   logic [TAG_W-1:0]  rd_t;

   initial begin
      rst = 1'b1; i_valid = 1'b0; i_addr = '0; d_valid = 1'b0; d_we = 1'b0;
      d_addr = '0; d_wdata = '0; d_tag = '0; g_pat = '0;
      step(1'b1, 0, '0, 0, 0, '0, '0, '0);
      step(1'b1, 0, '0, 0, 0, '0, '0, '0);
      idle(1);

      // write then read on the other port the very next cycle
      step(1'b0, 0, '0, 1, 1, 24'h000010, 24'hABCDEF, '0);
      step(1'b0, 1, 24'h000010, 0, 0, '0, '0, '0);
      idle(3);

      // back-to-back tagged D reads
      step(1'b0, 0, '0, 1, 1, 24'h000030, 24'h000011, '0);
      step(1'b0, 0, '0, 1, 1, 24'h000031, 24'h000022, '0);
      step(1'b0, 0, '0, 1, 1, 24'h000032, 24'h000033, '0);
      step(1'b0, 0, '0, 1, 0, 24'h000030, '0, 4'd1);
      step(1'b0, 0, '0, 1, 0, 24'h000031, '0, 4'd2);
      step(1'b0, 0, '0, 1, 0, 24'h000032, '0, 4'd3);
      idle(3);

      // both ports continuously requesting: D,D,D,I repeating
      for (int i = 0; i < 8; i++) step(1'b0, 1, 24'h000030, 1, 0, 24'h000031, '0, 4'd5);
      chk("grant_pattern", 64'(g_pat), 64'h11);
      idle(3);

      // reset right after a D read accept discards the in-flight response
      step(1'b0, 0, '0, 1, 0, 24'h000010, '0, 4'd7);
      step(1'b1, 0, '0, 0, 0, '0, '0, '0);
      idle(4);
      step(1'b0, 1, 24'h000010, 0, 0, '0, '0, '0);
      idle(3);

      // address wrap / bounds
      step(1'b0, 0, '0, 1, 1, 24'h000005, 24'h000111, '0);
      step(1'b0, 0, '0, 1, 1, 24'h001005, 24'h5A5A5A, '0);
      step(1'b0, 0, '0, 1, 0, 24'h000005, '0, 4'd9);
      step(1'b0, 1, 24'h001005, 0, 0, '0, '0, '0);
      idle(4);

      // simultaneous I read and D write of the same word
      step(1'b0, 1, 24'h000020, 1, 1, 24'h000020, 24'h123456, '0);
      step(1'b0, 1, 24'h000020, 0, 0, '0, '0, '0);
      idle(3);

      // randomized traffic over preloaded words 0..15 with optional upper address bits
      for (int a = 0; a < 16; a++)
         step(1'b0, 0, '0, 1, 1, ADDR_W'(a), DATA_W'($urandom), '0);
      ri_pend = 1'b0; rd_pend = 1'b0; ri_a = '0; rd_a = '0; rd_we = 1'b0; rd_wd = '0; rd_t = '0;
      for (int n = 0; n < 400; n++) begin
         if (!ri_pend && $urandom_range(0, 1) == 1) begin
            ri_pend = 1'b1;
            ri_a = ADDR_W'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) ri_a = ri_a + ADDR_W'($urandom_range(1, 4095) << 12);
         end
         if (!rd_pend && $urandom_range(0, 2) != 0) begin
            rd_pend = 1'b1;
            rd_we = 1'($urandom_range(0, 1));
            rd_wd = DATA_W'($urandom);
            rd_t  = TAG_W'($urandom);
            rd_a  = ADDR_W'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) rd_a = rd_a + ADDR_W'($urandom_range(1, 4095) << 12);
         end
         step(1'b0, ri_pend, ri_a, rd_pend, rd_we, rd_a, rd_wd, rd_t);
         if (m_gi) ri_pend = 1'b0;
         if (m_gd) rd_pend = 1'b0;
      end
      idle(LAT + 3);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/memresp.md
Name: memresp

Overview:
- Memory responder: the target end of the pipeline's memory request interface.
- Serves two requestors from one single-ported word array:
  - instruction port (I): driven by the address stage, read-only, data consumed by the fetch stage.
  - data port (D): driven by the memory-access stage, read/write, read data consumed by the memory-out stage.
- Per-cycle arbitration with starvation guard; fixed-latency pipelined read responses carrying the request's tag.

Parameters:
ADDR_W, 24, request address width in bits
DATA_W, 24, data word width in bits
DEPTH_LOG2, 12, log2 of array depth in words (4096)
LAT, 2, read latency in cycles from accept to response (1..4)
STARVE_MAX, 3, consecutive D grants allowed while I is pending before I is forced
TAG_W, 4, D-port request tag width

Ports:
iw_clk  in  1  clock
iw_rst  in  1  synchronous active-high reset
iw_i_valid  in  1  I-port read request valid
iw_i_addr  in  ADDR_W  I-port word address (PC)
ow_i_ready  out  1  I-port request accepted this cycle
ow_i_rvalid  out  1  I-port response valid
ow_i_rdata  out  DATA_W  I-port read data
ow_i_raddr  out  ADDR_W  address of the request being answered
iw_d_valid  in  1  D-port request valid
iw_d_we  in  1  1 = write, 0 = read
iw_d_addr  in  ADDR_W  D-port word address
iw_d_wdata  in  DATA_W  write data
iw_d_tag  in  TAG_W  request tag
ow_d_ready  out  1  D-port request accepted this cycle
ow_d_rvalid  out  1  D-port read response valid
ow_d_rdata  out  DATA_W  D-port read data
ow_d_rtag  out  TAG_W  tag of the read being answered
ow_fault  out  1  sticky out-of-range flag (feature-dependent)

Behaviour:
- Clock iw_clk, one clock domain; reset iw_rst synchronous, active-high.
- Reset values:
  - all ow_* outputs 0;
  - response pipe valids 0; starvation counter 0; fault 0;
  - array contents not cleared.
- Reset mid-operation: in-flight reads are discarded; no response appears after reset deasserts.
- Grant logic, combinational from current inputs and state:
  - force_i = iw_i_valid & iw_d_valid & (starve_cnt == STARVE_MAX)
  - grant_d = iw_d_valid & ~force_i
  - grant_i = iw_i_valid & ~grant_d
  - ow_d_ready = grant_d, ow_i_ready = grant_i. At most one grant per cycle.
  - Ready may depend combinationally on valid. Requestors hold valid and payload stable until ready.
- starve_cnt, updated every clock:
  - increments (saturating at STARVE_MAX) when grant_d & iw_i_valid;
  - resets to 0 when grant_i, or when I is not pending.
- Address handling: word index = addr[DEPTH_LOG2-1:0]. Upper bits are ignored; addresses wrap modulo depth (see optional feature).
- Write (grant_d & iw_d_we):
  - array updated at the accepting edge;
  - no response generated;
  - a read of the same word accepted in the next cycle, on either port, returns the new data.
- Read (accept in cycle N):
  - array read in cycle N; result carried through an LAT-stage pipe with {valid, port, addr/tag}.
  - Response visible in cycle N+LAT on the matching port's rvalid, for exactly one cycle.
  - Back-to-back reads give back-to-back responses, in order. No backpressure on responses.
- ow_i_raddr returns the full ADDR_W request address; ow_d_rtag returns iw_d_tag captured at accept.
- Both rvalids can never be high in the same cycle, because grants are exclusive.
- Throughput: 1 access per cycle total.

Optional Feature:
- MEMRESP_BOUNDS_EN defined:
  - an access with any address bit above DEPTH_LOG2-1 set is out of range;
  - out-of-range reads still respond at N+LAT, with rdata 0;
  - out-of-range writes are dropped;
  - ow_fault sets on the accepting edge and stays 1 until reset.
- Undefined: addresses wrap modulo depth, and ow_fault is tied 0.

Test Plan:
- After reset, D write addr 0x010 data 0xABCDEF, then I read 0x010 next cycle → ow_i_rvalid 2 cycles after accept, rdata 0xABCDEF, raddr 0x000010.
- D reads tags 1,2,3 on consecutive cycles to addrs holding 0x11,0x22,0x33 → rvalid 3 consecutive cycles starting accept+2; rtag 1,2,3; data in order.
- I and D both valid continuously, LAT=2, STARVE_MAX=3 → grant pattern D,D,D,I repeating; starve_cnt returns to 0 after each I grant.
- Reset asserted the cycle after a D read accept → no ow_d_rvalid afterwards; all outputs 0 during reset; array data written before reset still readable.
- Wrap: write 0x5A5A5A to addr 0x001005, read addr 0x000005 → returns 0x5A5A5A (feature off). With MEMRESP_BOUNDS_EN: write dropped; the read of 0x001005 returns 0; ow_fault=1 and stays 1.
- Simultaneous I read and D write, same addr 0x020 → D granted, write lands; I granted next cycle and reads the new value.
